// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks.
package uart_pkg;

   localparam int MinDataWidth = 5;

   typedef enum logic [1:0] {
      ParityNone = 2'd0,
      ParityEven = 2'd1,
      ParityOdd  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      Idle   = 3'd0,
      Start  = 3'd1,
      Data   = 3'd2,
      Parity = 3'd3,
      Stop   = 3'd4
   } rx_state_e;

   // Mode 3 is reserved and behaves as no parity.
   function automatic parity_e decode_parity(input logic [1:0] mode);
      case (mode)
         2'd1:    return ParityEven;
         2'd2:    return ParityOdd;
         default: return ParityNone;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs (rxd, cts).
// ResetVal sets the value both flops take in reset, e.g. 1 for an idle-high line.
module uart_sync #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // shift the raw input through two stages
   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   // synchroniser flops
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: 5..DataWidth data bits,
// none/even/odd parity, one or two stop bits, parity/framing/break detection.
// Optional macro UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote of the
// samples at Oversample/2-2 .. Oversample/2, decided one tick later.
//
// state  | meaning
// Idle   | waiting for a falling edge on an armed (seen-high) line
// Start  | timing to mid start bit to confirm it is still low
// Data   | sampling N data bits, one per Oversample ticks
// Parity | sampling the parity bit
// Stop   | sampling one or two stop bits, then publishing the frame
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DataWidth  = 8,
   parameter int Oversample = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           tick_i,
   input  logic                           rxd_i,
   input  logic [$clog2(DataWidth+1)-1:0] data_bits_i,
   input  logic [1:0]                     parity_i,
   input  logic                           stop2_i,
   output logic                           dv_o,
   output logic [DataWidth-1:0]           data_o,
   output logic                           parity_err_o,
   output logic                           frame_err_o,
   output logic                           break_o
);

   localparam int TW = $clog2(Oversample);
   localparam int BW = $clog2(DataWidth+1);
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam logic [TW-1:0] StartTc = TW'(Oversample/2);
`else
   localparam logic [TW-1:0] StartTc = TW'(Oversample/2 - 1);
`endif
   localparam logic [TW-1:0] BitTc   = TW'(Oversample - 1);
   localparam logic [BW-1:0] MaxBits = BW'(DataWidth);
   localparam logic [BW-1:0] MinBits = BW'(MinDataWidth);

   logic rxd_s;
   logic bit_val;

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [BW-1:0]        nbits_q, nbits_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   parity_e              par_q, par_d;
   logic                 stop2_q, stop2_d;
   logic                 idle_seen_q, idle_seen_d;
   logic                 par_acc_q, par_acc_d;
   logic                 pbit_q, pbit_d;
   logic                 stop_low_q, stop_low_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 dv_q, dv_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;

   logic [BW-1:0]        nbits_cfg;
   logic [BW-1:0]        drop;
   logic [DataWidth-1:0] word;
   logic                 stop_low_now;
   logic                 par_calc_err;

   uart_sync #(.ResetVal(1'b1)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (rxd_i),
      .q_o   (rxd_s)
   );

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] vote_q, vote_d;

   // remember the two previous tick samples for the 2-of-3 vote
   always_comb vote_d = tick_i ? {vote_q[0], rxd_s} : vote_q;

   // vote history flops, idle-high in reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vote_q <= 2'b11;
      else       vote_q <= vote_d;
   end

   assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
`else
   assign bit_val = rxd_s;
`endif

   // out-of-range bit counts fall back to the full width
   always_comb begin
      nbits_cfg = data_bits_i;
      if (data_bits_i < MinBits || data_bits_i > MaxBits) nbits_cfg = MaxBits;
   end

   assign drop         = MaxBits - nbits_q;
   assign word         = shift_q >> drop;
   assign stop_low_now = stop_low_q | ~bit_val;

   // parity check against the XOR of the received data bits
   always_comb begin
      case (par_q)
         ParityEven: par_calc_err = par_acc_q ^ pbit_q;
         ParityOdd:  par_calc_err = ~(par_acc_q ^ pbit_q);
         default:    par_calc_err = 1'b0;
      endcase
   end

   // receive state machine, advancing only on oversample ticks
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bcnt_d      = bcnt_q;
      nbits_d     = nbits_q;
      shift_d     = shift_q;
      par_d       = par_q;
      stop2_d     = stop2_q;
      idle_seen_d = idle_seen_q;
      par_acc_d   = par_acc_q;
      pbit_d      = pbit_q;
      stop_low_d  = stop_low_q;
      stop_idx_d  = stop_idx_q;
      dv_d        = 1'b0;
      data_d      = data_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      brk_d       = brk_q;
      if (tick_i) begin
         case (state_q)
            Idle: begin
               if (rxd_s) begin
                  idle_seen_d = 1'b1;
               end else if (idle_seen_q) begin
                  state_d = Start;
                  tcnt_d  = '0;
               end
            end
            Start: begin
               if (tcnt_q == StartTc) begin
                  if (!bit_val) begin
                     state_d    = Data;
                     tcnt_d     = '0;
                     bcnt_d     = '0;
                     nbits_d    = nbits_cfg;
                     par_d      = decode_parity(parity_i);
                     stop2_d    = stop2_i;
                     shift_d    = '0;
                     par_acc_d  = 1'b0;
                     pbit_d     = 1'b0;
                     stop_low_d = 1'b0;
                     stop_idx_d = 1'b0;
                  end else begin
                     state_d = Idle;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            Data: begin
               if (tcnt_q == BitTc) begin
                  tcnt_d    = '0;
                  shift_d   = {bit_val, shift_q[DataWidth-1:1]};
                  par_acc_d = par_acc_q ^ bit_val;
                  bcnt_d    = bcnt_q + 1'b1;
                  if (bcnt_q == nbits_q - 1'b1) begin
                     bcnt_d  = '0;
                     state_d = (par_q == ParityNone) ? Stop : Parity;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            Parity: begin
               if (tcnt_q == BitTc) begin
                  tcnt_d  = '0;
                  pbit_d  = bit_val;
                  state_d = Stop;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            Stop: begin
               if (tcnt_q == BitTc) begin
                  tcnt_d = '0;
                  if (stop2_q && !stop_idx_q) begin
                     stop_idx_d = 1'b1;
                     stop_low_d = stop_low_now;
                  end else begin
                     state_d     = Idle;
                     idle_seen_d = bit_val;
                     dv_d        = 1'b1;
                     data_d      = word;
                     perr_d      = par_calc_err;
                     ferr_d      = stop_low_now;
                     brk_d       = stop_low_now && (word == '0) &&
                                   (par_q == ParityNone || !pbit_q);
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            default: state_d = Idle;
         endcase
      end
   end

   // state, counters and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= Idle;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         nbits_q     <= '0;
         shift_q     <= '0;
         par_q       <= ParityNone;
         stop2_q     <= 1'b0;
         idle_seen_q <= 1'b1;
         par_acc_q   <= 1'b0;
         pbit_q      <= 1'b0;
         stop_low_q  <= 1'b0;
         stop_idx_q  <= 1'b0;
         dv_q        <= 1'b0;
         data_q      <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         brk_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         nbits_q     <= nbits_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         stop2_q     <= stop2_d;
         idle_seen_q <= idle_seen_d;
         par_acc_q   <= par_acc_d;
         pbit_q      <= pbit_d;
         stop_low_q  <= stop_low_d;
         stop_idx_q  <= stop_idx_d;
         dv_q        <= dv_d;
         data_q      <= data_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         brk_q       <= brk_d;
      end
   end

   assign dv_o         = dv_q;
   assign data_o       = data_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg (DataWidth=8, Oversample=16).
module tb_uart_rx_cfg;

   localparam int DW = 8;
   localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int            SOFF       = 9;
   localparam logic [7:0]    GLITCH_EXP = 8'h00;
`else
   localparam int            SOFF       = 8;
   localparam logic [7:0]    GLITCH_EXP = 8'h01;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       tick_i = 1'b0;
   logic       rxd_i = 1'b1;
   logic [3:0] data_bits_i = 4'd8;
   logic [1:0] parity_i = 2'd0;
   logic       stop2_i = 1'b0;
   logic       dv_o;
   logic [7:0] data_o;
   logic       parity_err_o, frame_err_o, break_o;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_cfg #(.DataWidth(DW), .Oversample(OS)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tick_i       (tick_i),
      .rxd_i        (rxd_i),
      .data_bits_i  (data_bits_i),
      .parity_i     (parity_i),
      .stop2_i      (stop2_i),
      .dv_o         (dv_o),
      .data_o       (data_o),
      .parity_err_o (parity_err_o),
      .frame_err_o  (frame_err_o),
      .break_o      (break_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       br;
   } rec_t;

   rec_t got[$];
   logic wave[$];

   always @(negedge clk_i) begin
      if (dv_o) got.push_back({data_o, parity_err_o, frame_err_o, break_o});
   end

   typedef struct {
      logic [3:0] db;
      logic [1:0] par;
      logic       st2;
      logic [7:0] d;
      int         nsend;
      logic       pb;
      logic       s1;
      logic       s2;
      logic [7:0] ed;
      logic       epe;
      logic       efe;
      logic       ebr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_frame(input string name, input logic [7:0] ed, input logic epe,
                              input logic efe, input logic ebr);
      rec_t r;
      check({name, " dv count"}, got.size(), 1);
      if (got.size() > 0) begin
         r = got.pop_front();
         check({name, " data"}, r.d, ed);
         check({name, " parity_err"}, r.pe, epe);
         check({name, " frame_err"}, r.fe, efe);
         check({name, " break"}, r.br, ebr);
      end
      got.delete();
   endtask

   // one oversample tick: line value set 3 clocks ahead so the synchroniser settles
   task automatic tick_step(input logic v);
      rxd_i = v;
      repeat (3) @(negedge clk_i);
      tick_i = 1'b1;
      @(negedge clk_i);
      tick_i = 1'b0;
   endtask

   task automatic play(input int lo, input int hi);
      for (int i = lo; i < hi; i++) tick_step(wave[i]);
   endtask

   task automatic add_bits(input logic v, input int nb);
      repeat (nb * OS) wave.push_back(v);
   endtask

   // two idle bits, start, data LSB first, optional parity, stops, two idle bits
   task automatic build_frame(input logic [7:0] d, input int n, input bit has_par,
                              input logic pb, input bit two, input logic s1, input logic s2);
      wave.delete();
      add_bits(1'b1, 2);
      add_bits(1'b0, 1);
      for (int i = 0; i < n; i++) add_bits(d[i], 1);
      if (has_par) add_bits(pb, 1);
      add_bits(s1, 1);
      if (two) add_bits(s2, 1);
      add_bits(1'b1, 2);
   endtask

   task automatic set_cfg(input logic [3:0] db, input logic [1:0] par, input logic st2);
      data_bits_i = db;
      parity_i    = par;
      stop2_i     = st2;
   endtask

   logic [3:0] r_db;
   logic [1:0] r_par;
   logic       r_st2, r_flip, r_s1, r_s2, r_pb, r_hp, r_epe, r_efe, r_ebr;
   logic [7:0] r_d, r_ed;
   int         r_n, idx;

   initial begin
      vecs[0] = '{4'd8, 2'd0, 1'b0, 8'hA5, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd7, 2'd1, 1'b0, 8'h35, 7, 1'b1, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'd7, 2'd1, 1'b0, 8'h35, 7, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'd8, 2'd0, 1'b1, 8'h81, 8, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{4'd5, 2'd2, 1'b0, 8'h1F, 5, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{4'd3, 2'd3, 1'b0, 8'h3C, 8, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{4'd6, 2'd0, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{4'd8, 2'd1, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk_i);
      check("reset dv", dv_o, 0);
      check("reset data", data_o, 0);
      check("reset flags", {parity_err_o, frame_err_o, break_o}, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // 8N1 0xA5 with dv latency at the mid-stop tick
      set_cfg(4'd8, 2'd0, 1'b0);
      build_frame(8'hA5, 8, 0, 1'b0, 0, 1'b1, 1'b1);
      idx = 2 * OS + 9 * OS + SOFF;
      play(0, idx);
      check("latency dv early", dv_o, 0);
      tick_step(wave[idx]);
      check("latency dv on", dv_o, 1);
      @(negedge clk_i);
      check("latency dv width", dv_o, 0);
      play(idx + 1, wave.size());
      check_frame("a5_8n1", 8'hA5, 1'b0, 1'b0, 1'b0);

      for (int v = 0; v < 8; v++) begin
         set_cfg(vecs[v].db, vecs[v].par, vecs[v].st2);
         build_frame(vecs[v].d, vecs[v].nsend, (vecs[v].par == 2'd1 || vecs[v].par == 2'd2),
                     vecs[v].pb, vecs[v].st2, vecs[v].s1, vecs[v].s2);
         play(0, wave.size());
         check_frame($sformatf("vec%0d", v), vecs[v].ed, vecs[v].epe, vecs[v].efe, vecs[v].ebr);
      end

      // false start: 4 low ticks, then a valid 0x3C
      set_cfg(4'd8, 2'd0, 1'b0);
      wave.delete();
      add_bits(1'b1, 1);
      repeat (4) wave.push_back(1'b0);
      add_bits(1'b1, 2);
      play(0, wave.size());
      check("false start dv", got.size(), 0);
      got.delete();
      build_frame(8'h3C, 8, 0, 1'b0, 0, 1'b1, 1'b1);
      play(0, wave.size());
      check_frame("after false start", 8'h3C, 1'b0, 1'b0, 1'b0);

      // break: line low for 12 bit times under 8N2, one frame only
      set_cfg(4'd8, 2'd0, 1'b1);
      wave.delete();
      add_bits(1'b1, 2);
      add_bits(1'b0, 12);
      add_bits(1'b1, 3);
      play(0, wave.size());
      check_frame("break", 8'h00, 1'b0, 1'b1, 1'b1);

      // reset during data bit 3 of 0xFF, tick asserted with it
      set_cfg(4'd8, 2'd0, 1'b0);
      build_frame(8'hFF, 8, 0, 1'b0, 0, 1'b1, 1'b1);
      idx = 2 * OS + 4 * OS + 4;
      play(0, idx);
      rst_i  = 1'b1;
      tick_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      check("mid reset flags", {parity_err_o, frame_err_o, break_o}, 0);
      check("mid reset data", data_o, 0);
      rst_i  = 1'b0;
      tick_i = 1'b0;
      play(idx, wave.size());
      check("mid reset no dv", got.size(), 0);
      got.delete();
      build_frame(8'h12, 8, 0, 1'b0, 0, 1'b1, 1'b1);
      play(0, wave.size());
      check_frame("after reset", 8'h12, 1'b0, 1'b0, 1'b0);

      // one-tick high glitch at the centre of data bit 0 of 0x00
      build_frame(8'h00, 8, 0, 1'b0, 0, 1'b1, 1'b1);
      wave[2 * OS + OS + 8] = 1'b1;
      play(0, wave.size());
      check_frame("glitch", GLITCH_EXP, 1'b0, 1'b0, 1'b0);

      // random frames against a reference computed from the frame rules
      for (int k = 0; k < 25; k++) begin
         r_db   = 4'($urandom_range(0, 15));
         r_par  = 2'($urandom_range(0, 3));
         r_st2  = 1'($urandom_range(0, 1));
         r_d    = 8'($urandom);
         r_flip = ($urandom_range(0, 2) == 0);
         r_s1   = ($urandom_range(0, 3) != 0);
         r_s2   = ($urandom_range(0, 3) != 0);
         r_n    = (r_db < 5 || r_db > 8) ? 8 : int'(r_db);
         r_ed   = 8'((int'(r_d)) & ((1 << r_n) - 1));
         r_hp   = (r_par == 2'd1 || r_par == 2'd2);
         r_pb   = ($countones(r_ed) % 2 == 1);
         if (r_par == 2'd2) r_pb = ~r_pb;
         r_pb   = r_pb ^ r_flip;
         r_epe  = r_hp & r_flip;
         r_efe  = ~r_s1 | (r_st2 & ~r_s2);
         r_ebr  = r_efe && (r_ed == 8'h00) && (!r_hp || !r_pb);
         set_cfg(r_db, r_par, r_st2);
         build_frame(r_d, r_n, r_hp, r_pb, r_st2, r_s1, r_s2);
         play(0, 3 * OS);
         set_cfg(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         play(3 * OS, wave.size());
         check_frame($sformatf("rand%0d", k), r_ed, r_epe, r_efe, r_ebr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Configurable UART receiver with oversampled, mid-bit sampling and runtime frame format: 5..DataWidth data bits, none/even/odd parity, 1 or 2 stop bits. Detects parity, framing and break errors, and rejects false start bits. Sits between the baud-tick generator (tick_i at Oversample x baud) and the UART peripheral register/FIFO layer. It is the next-generation replacement for the fixed 8N1 receiver.

Parameters:
DataWidth, 8, maximum data bits per frame; legal range 5..9.
Oversample, 16, tick_i pulses per bit period; must be even and >= 8.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
tick_i  input  1  single-cycle oversample strobe, Oversample per bit
rxd_i  input  1  asynchronous serial line; idle high
data_bits_i  input  $clog2(DataWidth+1)  data bits per frame; values <5 or >DataWidth are treated as DataWidth
parity_i  input  2  parity mode: 0 none, 1 even, 2 odd, 3 treated as none
stop2_i  input  1  1 = two stop bits, 0 = one stop bit
dv_o  output  1  one-clock pulse: frame complete; data_o and error flags valid
data_o  output  DataWidth  received word, LSB first on the line, right-justified; unused upper bits 0
parity_err_o  output  1  parity mismatch on the last frame
frame_err_o  output  1  a stop bit was sampled low
break_o  output  1  all data, parity and stop samples were low

Behaviour:
- Reset (async): all outputs 0; state Idle; synchroniser flops and the idle-seen flag set to 1; counters 0.
- rxd_i passes through a 2-flop synchroniser, reset to 1. All sampling uses the synchronised value.
- The FSM advances only on cycles with tick_i=1. Between ticks, all state holds.
- Tick counter width is $clog2(Oversample). Bit counter width is $clog2(DataWidth+1).
- Idle:
  - Arms only after the line has been sampled high on at least one tick (idle-seen flag). A stuck-low line never retriggers.
  - On a tick with the line low and armed, go to Start and clear the tick counter.
- Start:
  - At tick count Oversample/2-1 (mid start bit), sample the line.
  - Low: latch data_bits_i, parity_i and stop2_i; clear counters; go to Data. Config changes mid-frame are ignored.
  - High (false start): return to Idle with no dv_o.
- Data:
  - Sample every Oversample ticks, i.e. at the middle of each bit.
  - Each sample shifts into the MSB of the shift register.
  - After N samples (N = latched data bits), go to Parity if parity is enabled, else Stop.
- Parity: one sample; compute the parity error against the XOR of the data bits (even: XOR must equal the parity bit; odd: inverted).
- Stop: one or two samples; any low stop sample sets the frame error.
- On the last stop sample, the registered outputs update on the next clock edge:
  - data_o = shift register >> (DataWidth-N).
  - Error flags updated.
  - dv_o high for exactly one clock.
  - State returns to Idle; the idle-seen flag is cleared if the final sample was low.
- Latency: dv_o asserts 1 clk after the tick that samples the final stop bit.
- data_o and the error flags hold until the next dv_o.
- break_o = frame_err & all data bits 0 & (parity bit 0 or no parity).
- Reset mid-frame aborts the frame; no dv_o.
- Simultaneous tick_i and rst_i: reset wins.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: every bit value (start check, data, parity, stop) is the 2-of-3 majority of the samples at tick counts Oversample/2-2, Oversample/2-1 and Oversample/2. The decision is made at Oversample/2, one tick later than without the macro. A single-tick glitch is rejected.
- Undefined: single sample at Oversample/2-1; no vote registers.

Decomposition:
- uart_pkg:
  - parity_e enum (ParityNone, ParityEven, ParityOdd).
  - rx_state_e enum (Idle, Start, Data, Parity, Stop).
  - MinDataWidth=5 constant.
- Sub-module uart_sync: 2-flop synchroniser with a reset-value parameter. It is reused by uart_tx_cfg for cts.

Test Plan:
1. Oversample=16, 8N1, send 0xA5 -> one dv_o pulse; data_o=0xA5; all error flags 0; dv_o 1 clk after the mid-stop tick.
2. 7E1, send 0x35 with parity bit 1 (wrong) -> dv_o; data_o=0x35; parity_err_o=1. Resend with parity 0 -> parity_err_o=0.
3. rxd low for 4 ticks, then high -> no dv_o; FSM back in Idle; the next valid frame 0x3C is received correctly.
4. 8N2, send 0x81 with the second stop bit low -> frame_err_o=1, break_o=0. Send all-zero line for 12 bit times -> frame_err_o=1, break_o=1, data_o=0x00, and no second frame until the line returns high.
5. Assert rst_i during data bit 3 of 0xFF -> outputs 0, no dv_o. Next frame 0x12 is received correctly.
6. With UART_RX_MAJORITY_VOTE_EN: a 1-tick high glitch at the centre of data bit 0 of 0x00 -> data_o=0x00. Without the macro, the same glitch aligned to the sample tick -> data_o=0x01.
